// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the HSMC ADC 3-wire SPI configuration master.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    localparam int ADC_SPI_FRAME_BITS = 24;
    localparam int ADC_SPI_ADDR_W     = 13;
    localparam int ADC_SPI_DATA_W     = 8;

    // W1W0 = 00 selects a single-byte transfer
    localparam logic [1:0] ADC_SPI_W1W0 = 2'b00;

    // Assembles the MSB-first frame: instruction (rw, W1W0, address) then data
    function automatic logic [ADC_SPI_FRAME_BITS-1:0] build_frame(
        input logic                      rw,
        input logic [ADC_SPI_ADDR_W-1:0] addr,
        input logic [ADC_SPI_DATA_W-1:0] data
    );
        return {rw, ADC_SPI_W1W0, addr, data};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: emits a one-cycle tick at the end of every CLK_DIV-cycle phase.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running phase counter, restarted whenever the master enters a new state
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || (cnt == CNT_MAX)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/adc_spi_master.sv
// 3-wire SPI master for single-byte register access to the two HSMC ADCs.
// The top level owns the SDIO tristate; this block supplies drive value and enable.
module adc_spi_master
    import adc_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      rw,
    input  logic                      chip_sel,
    input  logic [ADC_SPI_ADDR_W-1:0] addr,
    input  logic [ADC_SPI_DATA_W-1:0] wdata,
    output logic                      busy,
    output logic                      done,
    output logic [ADC_SPI_DATA_W-1:0] rdata,
    output logic                      ad_sclk,
    output logic                      sdio_out,
    output logic                      sdio_oe,
    input  logic                      sdio_in,
    output logic                      ada_spi_cs,
    output logic                      adb_spi_cs
);

    localparam logic [4:0] LAST_BIT_IDX = 5'(ADC_SPI_FRAME_BITS - 1);
    localparam logic [4:0] FIRST_DATA_TURN = 5'd8;

    spi_state_t                        state_q, state_d;
    logic [ADC_SPI_FRAME_BITS-1:0]     shift_q, shift_d;
    logic [4:0]                        bit_cnt_q, bit_cnt_d;
    logic                              rw_q, rw_d;
    logic                              gap_half_q, gap_half_d;
    logic [ADC_SPI_DATA_W-1:0]         rx_q, rx_d;

    logic                              busy_d, done_d, sclk_d, sdio_out_d, sdio_oe_d;
    logic                              cs_a_d, cs_b_d;
    logic [ADC_SPI_DATA_W-1:0]         rdata_d;

    logic                              tick, tick_clr, gap_end;

    // Keep the phase timer at zero while idle and restart it on every state change
    assign tick_clr = (state_d != state_q) || (state_q == IDLE);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .clear   (tick_clr),
        .tick    (tick)
    );

    // State and output registers; every port output comes straight from a flop
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rw_q       <= 1'b0;
            gap_half_q <= 1'b0;
            rx_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            ad_sclk    <= 1'b0;
            sdio_out   <= 1'b0;
            sdio_oe    <= 1'b0;
            ada_spi_cs <= 1'b1;
            adb_spi_cs <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rw_q       <= rw_d;
            gap_half_q <= gap_half_d;
            rx_q       <= rx_d;
            busy       <= busy_d;
            done       <= done_d;
            rdata      <= rdata_d;
            ad_sclk    <= sclk_d;
            sdio_out   <= sdio_out_d;
            sdio_oe    <= sdio_oe_d;
            ada_spi_cs <= cs_a_d;
            adb_spi_cs <= cs_b_d;
        end
    end

    // Next-state and next-output logic; a new command may also be taken on the
    // final GAP edge so a held start runs transactions back to back
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        gap_half_d = gap_half_q;
        rx_d       = rx_q;
        busy_d     = busy;
        done_d     = 1'b0;
        rdata_d    = rdata;
        sclk_d     = ad_sclk;
        sdio_out_d = sdio_out;
        sdio_oe_d  = sdio_oe;
        cs_a_d     = ada_spi_cs;
        cs_b_d     = adb_spi_cs;
        gap_end    = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d    = 1'b0;
                sdio_oe_d = 1'b0;
            end

            SHIFT: begin
                if (tick) begin
                    if (!ad_sclk) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[ADC_SPI_DATA_W-2:0], sdio_in};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == 5'd0) begin
                            state_d    = HOLD;
                            sdio_out_d = 1'b0;
                            sdio_oe_d  = 1'b0;
                        end else begin
                            bit_cnt_d  = bit_cnt_q - 5'd1;
                            shift_d    = {shift_q[ADC_SPI_FRAME_BITS-2:0], 1'b0};
                            sdio_out_d = shift_q[ADC_SPI_FRAME_BITS-2];
                            if (rw_q && (bit_cnt_q == FIRST_DATA_TURN)) begin
                                sdio_oe_d = 1'b0;
                            end
                        end
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    state_d    = GAP;
                    gap_half_d = 1'b0;
                    cs_a_d     = 1'b1;
                    cs_b_d     = 1'b1;
                end
            end

            GAP: begin
                if (tick) begin
                    if (!gap_half_q) begin
                        gap_half_d = 1'b1;
                    end else begin
                        gap_end = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                        if (rw_q) begin
                            rdata_d = rx_q;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (start && ((state_q == IDLE) || gap_end)) begin
            shift_d    = build_frame(rw, addr, rw ? '0 : wdata);
            sdio_out_d = rw;
            sdio_oe_d  = 1'b1;
            sclk_d     = 1'b0;
            busy_d     = 1'b1;
            rw_d       = rw;
            bit_cnt_d  = LAST_BIT_IDX;
            cs_a_d     = chip_sel;
            cs_b_d     = ~chip_sel;
            state_d    = SHIFT;
        end
    end

endmodule

// File: tb/tb_adc_spi_master.sv
// Directed self-checking bench for adc_spi_master (CLK_DIV=4 and CLK_DIV=1 instances).
module tb_adc_spi_master;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic reset_n;

    logic        start, rw, chip_sel;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic        busy, done, ad_sclk, sdio_out, sdio_oe, sdio_in, ada_spi_cs, adb_spi_cs;
    logic [7:0]  rdata;

    logic        start_f, rw_f, chip_sel_f;
    logic [12:0] addr_f;
    logic [7:0]  wdata_f;
    logic        busy_f, done_f, ad_sclk_f, sdio_out_f, sdio_oe_f, ada_spi_cs_f, adb_spi_cs_f;
    logic [7:0]  rdata_f;

    int compared   = 0;
    int mismatched = 0;

    adc_spi_master #(.CLK_DIV(4)) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .start      (start),
        .rw         (rw),
        .chip_sel   (chip_sel),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .ad_sclk    (ad_sclk),
        .sdio_out   (sdio_out),
        .sdio_oe    (sdio_oe),
        .sdio_in    (sdio_in),
        .ada_spi_cs (ada_spi_cs),
        .adb_spi_cs (adb_spi_cs)
    );

    adc_spi_master #(.CLK_DIV(1)) dut_fast (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .start      (start_f),
        .rw         (rw_f),
        .chip_sel   (chip_sel_f),
        .addr       (addr_f),
        .wdata      (wdata_f),
        .busy       (busy_f),
        .done       (done_f),
        .rdata      (rdata_f),
        .ad_sclk    (ad_sclk_f),
        .sdio_out   (sdio_out_f),
        .sdio_oe    (sdio_oe_f),
        .sdio_in    (1'b1),
        .ada_spi_cs (ada_spi_cs_f),
        .adb_spi_cs (adb_spi_cs_f)
    );

    // ADC-side model: captures SDIO on SCLK rising edges and returns slave_byte during the data phase
    logic        prev_sclk  = 1'b0;
    int          rise_cnt   = 0;
    logic [23:0] cap        = '0;
    logic        slave_bit  = 1'b0;
    logic [7:0]  slave_byte = 8'hA5;

    always @(negedge sys_clk) begin
        prev_sclk <= ad_sclk;
        if (ada_spi_cs && adb_spi_cs) begin
            rise_cnt <= 0;
        end else if (ad_sclk && !prev_sclk) begin
            cap      <= {cap[22:0], sdio_out};
            rise_cnt <= rise_cnt + 1;
        end else if (!ad_sclk && prev_sclk && rise_cnt >= 16 && rise_cnt < 24) begin
            slave_bit <= slave_byte[3'(23 - rise_cnt)];
        end
    end

    assign sdio_in = sdio_oe ? sdio_out : slave_bit;

    // Per-transaction observations gathered by run_txn
    int         r_done_k, r_cs_low, r_other_low, r_oe_cnt, r_oe_drop;
    logic       r_got, r_busy_at;
    logic [7:0] r_rdata_at;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic run_txn(input logic t_rw, input logic t_sel, input logic [12:0] t_addr,
                           input logic [7:0] t_wdata, input int poke_k, input bit poke_is_reset);
        logic cs_self, cs_other;
        r_done_k = -1; r_cs_low = 0; r_other_low = 0; r_oe_cnt = 0; r_oe_drop = -1;
        r_got = 1'b0; r_busy_at = 1'bx; r_rdata_at = 'x;
        @(negedge sys_clk);
        rw = t_rw; chip_sel = t_sel; addr = t_addr; wdata = t_wdata; start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge sys_clk);
            if (k == poke_k) begin
                if (poke_is_reset) begin
                    reset_n = 1'b0;
                    #1;
                    check_output("rst_mid_ada_cs", ada_spi_cs, 1'b1);
                    check_output("rst_mid_adb_cs", adb_spi_cs, 1'b1);
                    check_output("rst_mid_sclk", ad_sclk, 1'b0);
                    check_output("rst_mid_oe", sdio_oe, 1'b0);
                    check_output("rst_mid_busy", busy, 1'b0);
                    check_output("rst_mid_done", done, 1'b0);
                    return;
                end else begin
                    start = 1'b1;
                end
            end
            if (k == poke_k + 1) start = 1'b0;
            cs_self  = t_sel ? adb_spi_cs : ada_spi_cs;
            cs_other = t_sel ? ada_spi_cs : adb_spi_cs;
            if (!cs_self) r_cs_low++;
            if (!cs_other) r_other_low++;
            if (sdio_oe) r_oe_cnt++;
            if (!sdio_oe && !cs_self && r_oe_drop < 0) r_oe_drop = k;
            if (done) begin
                r_done_k   = k;
                r_busy_at  = busy;
                r_rdata_at = rdata;
                r_got      = 1'b1;
                break;
            end
        end
        check_output("done_seen", r_got, 1'b1);
    endtask

    int   done_cnt, cs_hi_cnt, n_done, d0, d1, d2, other_low_f;
    logic cs_at_d0;
    logic [7:0] rdata_first;

    initial begin
        reset_n = 1'b0; start = 1'b0; rw = 1'b0; chip_sel = 1'b0; addr = '0; wdata = '0;
        start_f = 1'b0; rw_f = 1'b0; chip_sel_f = 1'b0; addr_f = '0; wdata_f = '0;

        // Reset values
        repeat (3) @(negedge sys_clk);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_rdata", rdata, 8'h00);
        check_output("rst_sclk", ad_sclk, 1'b0);
        check_output("rst_sdio_out", sdio_out, 1'b0);
        check_output("rst_oe", sdio_oe, 1'b0);
        check_output("rst_cs", {ada_spi_cs, adb_spi_cs}, 2'b11);
        reset_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Write to ADC A, addr 0x014, data 0x01
        $display("[TB] write ADC A");
        run_txn(1'b0, 1'b0, 13'h014, 8'h01, -10, 1'b0);
        check_output("wr_capture", cap, 24'h001401);
        check_output("wr_cs_low", r_cs_low, 196);
        check_output("wr_other_cs", r_other_low, 0);
        check_output("wr_oe_cycles", r_oe_cnt, 192);
        check_output("wr_done_k", r_done_k, 204);
        check_output("wr_busy_at_done", r_busy_at, 1'b0);
        check_output("wr_rdata", r_rdata_at, 8'h00);

        // Read from ADC B, addr 0x001, slave returns 0xA5
        $display("[TB] read ADC B");
        run_txn(1'b1, 1'b1, 13'h001, 8'h3C, -10, 1'b0);
        check_output("rd_instr", cap[23:8], 16'h8001);
        check_output("rd_oe_drop_k", r_oe_drop, 128);
        check_output("rd_oe_cycles", r_oe_cnt, 128);
        check_output("rd_other_cs", r_other_low, 0);
        check_output("rd_done_k", r_done_k, 204);
        check_output("rd_rdata", r_rdata_at, 8'hA5);

        // Start pulsed mid-transaction is ignored
        $display("[TB] start while busy");
        run_txn(1'b0, 1'b0, 13'h0FF, 8'h5A, 50, 1'b0);
        check_output("ign_done_k", r_done_k, 204);
        check_output("ign_rdata_kept", r_rdata_at, 8'hA5);
        done_cnt = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge sys_clk);
            if (done) done_cnt++;
        end
        check_output("ign_extra_done", done_cnt, 0);
        check_output("ign_busy_idle", busy, 1'b0);

        // Reset during bit 12 (low phase of frame bit index 11)
        $display("[TB] reset mid-transaction");
        run_txn(1'b0, 1'b0, 13'h014, 8'h77, 90, 1'b1);
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge sys_clk);
            if (done) done_cnt++;
        end
        check_output("rst_no_done", done_cnt, 0);
        check_output("rst_rdata_cleared", rdata, 8'h00);
        run_txn(1'b0, 1'b1, 13'h014, 8'h01, -10, 1'b0);
        check_output("post_rst_capture", cap, 24'h001401);
        check_output("post_rst_done_k", r_done_k, 204);
        check_output("post_rst_cs_low", r_cs_low, 196);

        // CLK_DIV=1, back-to-back reads with start held high
        $display("[TB] back-to-back reads, CLK_DIV=1");
        n_done = 0; d0 = -1; d1 = -1; d2 = -1; cs_hi_cnt = 0; other_low_f = 0;
        cs_at_d0 = 1'bx; rdata_first = 'x;
        @(negedge sys_clk);
        rw_f = 1'b1; chip_sel_f = 1'b0; addr_f = 13'h005; start_f = 1'b1;
        @(posedge sys_clk);
        for (int k = 0; k < 300; k++) begin
            @(negedge sys_clk);
            if (n_done == 0 && ada_spi_cs_f) cs_hi_cnt++;
            if (!adb_spi_cs_f) other_low_f++;
            if (done_f) begin
                if (n_done == 0) begin
                    d0 = k; cs_at_d0 = ada_spi_cs_f; rdata_first = rdata_f;
                end else if (n_done == 1) begin
                    d1 = k;
                end else begin
                    d2 = k;
                end
                n_done++;
            end
            if (n_done == 3) break;
        end
        start_f = 1'b0;
        check_output("b2b_first_done_k", d0, 51);
        check_output("b2b_period_1", d1 - d0, 51);
        check_output("b2b_period_2", d2 - d1, 51);
        check_output("b2b_cs_gap", cs_hi_cnt, 2);
        check_output("b2b_cs_restart", cs_at_d0, 1'b0);
        check_output("b2b_other_cs", other_low_f, 0);
        check_output("b2b_rdata", rdata_first, 8'hFF);
        done_cnt = 0;
        for (int k = 0; k < 100 && busy_f; k++) @(negedge sys_clk);
        check_output("b2b_busy_drops", busy_f, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
